// File: rtl/tur_sequencer.sv
// Two-player round controller for the tur scoring datapath: takes one move per
// player per round over valid/ready, scores the pair and keeps running totals.
module tur_sequencer #(
  parameter int ROUNDS    = 8,
  parameter int SCORE_W   = 6,
  parameter int WIN_SCORE = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               p1_valid,
  input  logic [1:0]         p1_x,
  input  logic [1:0]         p1_y,
  output logic               p1_ready,
  input  logic               p2_valid,
  input  logic [1:0]         p2_x,
  input  logic [1:0]         p2_y,
  output logic               p2_ready,
  output logic               round_done,
  output logic [2:0]         round_sum,
  output logic               round_bonus,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [3:0]         round_cnt,
  output logic               busy,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_A = 3'd1;
  localparam logic [2:0] S_WAIT_B = 3'd2;
  localparam logic [2:0] S_EVAL   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [SCORE_W:0] MAX_V = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0] WIN_V = (SCORE_W+1)'(WIN_SCORE);

  // Handshake contract: a player's ready depends only on state and turn order,
  // never on its valid; a move transfers on any rising edge with valid & ready.

  function automatic logic [1:0] pts(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0)      return 2'd0;
    else if (x == 2'd2 && y == 2'd2) return 2'd3;
    else if (x == 2'd2 || y == 2'd2) return 2'd2;
    else                             return 2'd1;
  endfunction

  logic [2:0]         state;
  logic [1:0]         m1_x, m1_y, m2_x, m2_y;
  logic               first_p1, in_wait, serve_p1, hs1, hs2;
  logic [1:0]         pa, pb;
  logic [2:0]         sum, add1, add2;
  logic               bonus;
  logic [SCORE_W:0]   t1, t2;
  logic [SCORE_W-1:0] s1_n, s2_n;
  logic [3:0]         cnt_n;
  logic               game_end;
  logic [1:0]         win_n;

  assign first_p1 = ~round_cnt[0];
  assign in_wait  = (state == S_WAIT_A) || (state == S_WAIT_B);
  assign serve_p1 = ((state == S_WAIT_A) && first_p1) || ((state == S_WAIT_B) && !first_p1);
  assign p1_ready = serve_p1;
  assign p2_ready = in_wait && !serve_p1;
  assign hs1      = p1_valid & p1_ready;
  assign hs2      = p2_valid & p2_ready;

  assign busy      = in_wait || (state == S_EVAL);
  assign game_over = (state == S_DONE);
  assign state_dbg = state;

  // Round evaluation from the latched moves; a 3/3 tie earns no extra point.
  assign pa    = pts(m1_x, m1_y);
  assign pb    = pts(m2_x, m2_y);
  assign sum   = {1'b0, pa} + {1'b0, pb};
  assign bonus = (sum >= 3'd5);
  assign add1  = {1'b0, pa} + ((bonus && (pa > pb)) ? 3'd1 : 3'd0);
  assign add2  = {1'b0, pb} + ((bonus && (pb > pa)) ? 3'd1 : 3'd0);
  assign t1    = {1'b0, score1} + (SCORE_W+1)'(add1);
  assign t2    = {1'b0, score2} + (SCORE_W+1)'(add2);
  assign s1_n  = (t1 > MAX_V) ? MAX_V[SCORE_W-1:0] : t1[SCORE_W-1:0];
  assign s2_n  = (t2 > MAX_V) ? MAX_V[SCORE_W-1:0] : t2[SCORE_W-1:0];
  assign cnt_n = round_cnt + 4'd1;

  assign game_end = (cnt_n == 4'(ROUNDS)) ||
                    ({1'b0, s1_n} >= WIN_V) || ({1'b0, s2_n} >= WIN_V);
  assign win_n    = (s1_n > s2_n) ? 2'b01 : (s2_n > s1_n) ? 2'b10 : 2'b11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      m1_x        <= 2'd0;
      m1_y        <= 2'd0;
      m2_x        <= 2'd0;
      m2_y        <= 2'd0;
      round_done  <= 1'b0;
      round_sum   <= 3'd0;
      round_bonus <= 1'b0;
      score1      <= '0;
      score2      <= '0;
      round_cnt   <= 4'd0;
      winner      <= 2'b00;
    end else begin
      round_done <= 1'b0;
      if (hs1) begin
        m1_x <= p1_x;
        m1_y <= p1_y;
      end
      if (hs2) begin
        m2_x <= p2_x;
        m2_y <= p2_y;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score1      <= '0;
            score2      <= '0;
            round_cnt   <= 4'd0;
            round_sum   <= 3'd0;
            round_bonus <= 1'b0;
            winner      <= 2'b00;
            state       <= S_WAIT_A;
          end
        end
        S_WAIT_A: if (hs1 || hs2) state <= S_WAIT_B;
        S_WAIT_B: if (hs1 || hs2) state <= S_EVAL;
        S_EVAL: begin
          round_sum   <= sum;
          round_bonus <= bonus;
          score1      <= s1_n;
          score2      <= s2_n;
          round_cnt   <= cnt_n;
          round_done  <= 1'b1;
          if (game_end) begin
            winner <= win_n;
            state  <= S_DONE;
          end else begin
            state  <= S_WAIT_A;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
